multi_channel_moving_average: RTL and testbench
===============================================

Name: multi_channel_moving_average

Overview:
Parametrised successor to the single-channel heatwatch moving-average filter. Accepts temperature samples tagged with a channel number and keeps an independent sliding window per channel. Emits each channel's windowed average one cycle after every accepted sample, with a per-channel over-temperature alarm that uses hysteresis. Sits between the sensor sampling front-end and the heatwatch display/alert logic.

Parameters:
DATA_W, 11, sample and average width (unsigned).
LOG2_DEPTH, 2, window depth is 2**LOG2_DEPTH samples per channel; must be at least 1.
NUM_CH, 4, number of independent channels; must be at least 1.
CH_W, $clog2(NUM_CH) (min 1), channel index width; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
clear  in  1  synchronous flush of all channel windows.
in_valid  in  1  sample strobe, one sample per cycle max.
in_channel  in  CH_W  channel tag of the sample.
data_input  in  DATA_W  unsigned sample.
alarm_hi  in  DATA_W  alarm set threshold (quasi-static).
alarm_lo  in  DATA_W  alarm clear threshold, alarm_lo <= alarm_hi.
out_valid  out  1  result strobe.
out_channel  out  CH_W  channel of the result.
result_output  out  DATA_W  windowed average.
window_full  out  1  that channel has received at least DEPTH samples since reset or clear.
alarm  out  NUM_CH  per-channel alarm level.
err_channel  out  1  one-cycle pulse: in_channel >= NUM_CH.

Behaviour:
- Reset (async assert, sync release): all windows, sums, pointers and counts go to 0. out_valid=0, out_channel=0, result_output=0, window_full=0, alarm=0, err_channel=0.
- Per-channel state:
  - DEPTH-entry ring buffer.
  - Write pointer, wrapping from DEPTH-1 to 0.
  - Fill count, saturating at DEPTH.
  - Running sum, width DATA_W+LOG2_DEPTH; it cannot overflow.
- Accepted sample (in_valid=1, in_channel<NUM_CH, clear=0), on the edge:
  - sum_new = sum - buf[ptr] + data_input.
  - buf[ptr] = data_input; ptr advances; count increments (saturating).
- Latency: exactly 1 cycle. Next cycle the block drives:
  - out_valid=1, out_channel=tag.
  - result_output = sum_new >> LOG2_DEPTH (truncating).
  - window_full = (count_new == DEPTH).
- Partial window: before the window fills, empty slots count as 0. The output is not rescaled; window_full qualifies it.
- Idle cycles: out_valid=0; result_output, out_channel and window_full hold their last values.
- Back-to-back samples on the same channel every cycle are fully supported; no stall or ready signal exists.
- Alarm, evaluated in the same update as the result:
  - alarm[ch] sets when window_full_new and avg >= alarm_hi.
  - alarm[ch] clears when avg < alarm_lo.
  - Otherwise alarm[ch] holds. Only the sampled channel's bit can change.
- clear=1:
  - All buffers, sums, pointers, counts and alarm bits go to 0 on that edge; next cycle out_valid=0.
  - A simultaneous in_valid sample is dropped (clear wins).
- Invalid channel (in_valid=1, in_channel>=NUM_CH): the sample is dropped with no state change, out_valid=0 next cycle, err_channel=1 for one cycle.
- Reset mid-operation clears everything immediately, including a pending out_valid.

Decomposition:
- Shared heatwatch package holds:
  - Default DATA_W, the sum-width function (DATA_W+LOG2_DEPTH).
  - Channel index type.
  - Sample and average typedefs.
- One sub-module: ma_channel_window. It holds one channel's ring buffer, pointer, count and sum, and computes sum_new and count_new. The top instantiates NUM_CH of these via generate, and does the channel decode, output register and alarm logic.

Test Plan:
- Defaults, thresholds 2047/2047, ch0 samples 4,8,12,16 -> results 1,3,6,10 one cycle after each; window_full=1 only on the 4th. Then sample 20 -> 14.
- Interleaved ch0=100, ch1=200, repeated 4 times each -> ch0 results 25,50,75,100 and ch1 results 50,100,150,200; out_channel matches each sample; no cross-talk.
- Four samples of 2047 on ch3, back-to-back cycles -> 511,1023,1535,2047; window_full=1 on the last; no overflow.
- alarm_hi=100, alarm_lo=90, ch2 window of 100s -> alarm[2]=1 with the 4th result. Then samples 92 -> avg 98, alarm holds. Then three more 92s (last avg 92) -> alarm still held. Then 80 -> avg 89, alarm[2]=0.
- clear asserted together with in_valid (ch0, 50) after ch0 is full -> next cycle out_valid=0, alarm=0. Next ch0 sample 40 -> result 10, window_full=0.
- NUM_CH=3 build, in_channel=3 -> err_channel pulse, out_valid=0. Then reset asserted mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/multi_channel_moving_average_pkg.sv
// Shared heatwatch definitions for the multi-channel moving-average filter:
// default widths, derived-width helpers and sample/average/channel types.
package multi_channel_moving_average_pkg;

    localparam int DEFAULT_DATA_W     = 11;
    localparam int DEFAULT_LOG2_DEPTH = 2;
    localparam int DEFAULT_NUM_CH     = 4;

    // Running sum of 2**log2_depth samples never exceeds this width.
    function automatic int sum_width(input int data_w, input int log2_depth);
        return data_w + log2_depth;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    localparam int DEFAULT_CH_W = ch_width(DEFAULT_NUM_CH);

    typedef logic [DEFAULT_CH_W-1:0]   ch_idx_t;
    typedef logic [DEFAULT_DATA_W-1:0] sample_t;
    typedef logic [DEFAULT_DATA_W-1:0] avg_t;

endpackage

// File: rtl/multi_channel_moving_average_window.sv
// One channel's sliding window: ring buffer, write pointer, saturating fill
// count and running sum, plus the combinational post-update sum and count.
module ma_channel_window
    import multi_channel_moving_average_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH,
    localparam int SUM_W     = sum_width(DATA_W, LOG2_DEPTH),
    localparam int CNT_W     = LOG2_DEPTH + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_data,
    output logic [SUM_W-1:0]  o_sum_new,
    output logic [CNT_W-1:0]  o_count_new
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0]     r_buf [DEPTH];
    logic [LOG2_DEPTH-1:0] r_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [SUM_W-1:0]      r_sum;
    logic [DATA_W-1:0]     w_old;

    // Empty slots hold 0, so subtracting them is harmless while filling.
    assign w_old       = r_buf[r_ptr];
    assign o_sum_new   = r_sum - SUM_W'(w_old) + SUM_W'(i_data);
    assign o_count_new = (r_count == FULL_CNT) ? r_count : r_count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            r_sum   <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            r_sum   <= '0;
        end else if (i_we) begin
            r_buf[r_ptr] <= i_data;
            r_ptr        <= r_ptr + 1'b1;
            r_count      <= o_count_new;
            r_sum        <= o_sum_new;
        end
    end

endmodule

// File: rtl/multi_channel_moving_average.sv
// Multi-channel moving-average filter: decodes the channel tag, updates that
// channel's window, registers the average and tracks a hysteresis alarm.
module multi_channel_moving_average
    import multi_channel_moving_average_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH,
    parameter int NUM_CH     = DEFAULT_NUM_CH,
    localparam int CH_W      = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_channel,
    input  logic [DATA_W-1:0] data_input,
    input  logic [DATA_W-1:0] alarm_hi,
    input  logic [DATA_W-1:0] alarm_lo,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_channel,
    output logic [DATA_W-1:0] result_output,
    output logic              window_full,
    output logic [NUM_CH-1:0] alarm,
    output logic              err_channel
);

    localparam int SUM_W = sum_width(DATA_W, LOG2_DEPTH);
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(2 ** LOG2_DEPTH);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic              w_ch_ok;
    logic              w_accept;
    logic [NUM_CH-1:0] w_we;
    logic [SUM_W-1:0]  w_sum_new [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_new [NUM_CH];
    logic [SUM_W-1:0]  w_sel_sum;
    logic [CNT_W-1:0]  w_sel_cnt;
    logic [DATA_W-1:0] w_avg;
    logic              w_full_new;
    logic [NUM_CH-1:0] w_alarm_next;

    logic              r_out_valid;
    logic [CH_W-1:0]   r_out_channel;
    logic [DATA_W-1:0] r_result;
    logic              r_window_full;
    logic [NUM_CH-1:0] r_alarm;
    logic              r_err_channel;

    assign w_ch_ok  = ({1'b0, in_channel} < NUM_CH_L);
    assign w_accept = in_valid && !clear && w_ch_ok;

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        assign w_we[g] = w_accept && (in_channel == CH_W'(g));

        ma_channel_window #(
            .DATA_W     (DATA_W),
            .LOG2_DEPTH (LOG2_DEPTH)
        ) u_window (
            .clk         (clk),
            .reset       (reset),
            .i_clear     (clear),
            .i_we        (w_we[g]),
            .i_data      (data_input),
            .o_sum_new   (w_sum_new[g]),
            .o_count_new (w_cnt_new[g])
        );
    end

    always_comb begin
        w_sel_sum = '0;
        w_sel_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_channel == CH_W'(i)) begin
                w_sel_sum = w_sum_new[i];
                w_sel_cnt = w_cnt_new[i];
            end
        end
    end

    assign w_avg      = w_sel_sum[SUM_W-1:LOG2_DEPTH];
    assign w_full_new = (w_sel_cnt == FULL_CNT);

    // Set and clear bands cannot overlap while alarm_lo <= alarm_hi.
    always_comb begin
        w_alarm_next = r_alarm;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_we[i]) begin
                if (w_full_new && (w_avg >= alarm_hi)) begin
                    w_alarm_next[i] = 1'b1;
                end else if (w_avg < alarm_lo) begin
                    w_alarm_next[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_channel <= '0;
            r_result      <= '0;
            r_window_full <= 1'b0;
            r_alarm       <= '0;
            r_err_channel <= 1'b0;
        end else begin
            r_out_valid   <= w_accept;
            r_err_channel <= in_valid && !w_ch_ok;
            r_alarm       <= clear ? '0 : w_alarm_next;
            if (w_accept) begin
                r_out_channel <= in_channel;
                r_result      <= w_avg;
                r_window_full <= w_full_new;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_channel   = r_out_channel;
    assign result_output = r_result;
    assign window_full   = r_window_full;
    assign alarm         = r_alarm;
    assign err_channel   = r_err_channel;

endmodule

// File: tb/tb_multi_channel_moving_average.sv
// Directed bench: table of per-cycle vectors for the 4-channel build, plus
// hand sequences for invalid channel and async reset on a 3-channel build.
module tb_multi_channel_moving_average;

    typedef struct {
        logic        clr;
        logic        vld;
        logic [1:0]  ch;
        logic [10:0] data;
        logic [10:0] hi;
        logic [10:0] lo;
        logic        ov;
        logic [1:0]  och;
        logic [10:0] res;
        logic        full;
        logic [3:0]  al;
    } vec_t;

    localparam logic [10:0] H = 11'd2047;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel DUT
    logic        rst, clr, vld, ov, full, err;
    logic [1:0]  ch, och;
    logic [10:0] data, hi, lo, res;
    logic [3:0]  al;

    // 3-channel DUT
    logic        b_rst, b_clr, b_vld, b_ov, b_full, b_err;
    logic [1:0]  b_ch, b_och;
    logic [10:0] b_data, b_hi, b_lo, b_res;
    logic [2:0]  b_al;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    multi_channel_moving_average #(
        .DATA_W     (11),
        .LOG2_DEPTH (2),
        .NUM_CH     (4)
    ) u_dut (
        .clk           (clk),
        .reset         (rst),
        .clear         (clr),
        .in_valid      (vld),
        .in_channel    (ch),
        .data_input    (data),
        .alarm_hi      (hi),
        .alarm_lo      (lo),
        .out_valid     (ov),
        .out_channel   (och),
        .result_output (res),
        .window_full   (full),
        .alarm         (al),
        .err_channel   (err)
    );

    multi_channel_moving_average #(
        .DATA_W     (11),
        .LOG2_DEPTH (2),
        .NUM_CH     (3)
    ) u_dut3 (
        .clk           (clk),
        .reset         (b_rst),
        .clear         (b_clr),
        .in_valid      (b_vld),
        .in_channel    (b_ch),
        .data_input    (b_data),
        .alarm_hi      (b_hi),
        .alarm_lo      (b_lo),
        .out_valid     (b_ov),
        .out_channel   (b_och),
        .result_output (b_res),
        .window_full   (b_full),
        .alarm         (b_al),
        .err_channel   (b_err)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic v, input logic [1:0] cc,
                       input logic [10:0] d, input logic [10:0] h, input logic [10:0] l,
                       input logic eov, input logic [1:0] eoch, input logic [10:0] eres,
                       input logic efull, input logic [3:0] eal);
        vec_t t;
        t.clr = c; t.vld = v; t.ch = cc; t.data = d; t.hi = h; t.lo = l;
        t.ov = eov; t.och = eoch; t.res = eres; t.full = efull; t.al = eal;
        vecs.push_back(t);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; vld = 1'b0; ch = '0; data = '0; hi = H; lo = H;
        b_rst = 1'b1; b_clr = 1'b0; b_vld = 1'b0; b_ch = '0; b_data = '0;
        b_hi = H; b_lo = 11'd0;

        // ch0 ramp, idle hold, clear
        add(0, 1, 0,   4, H, H,  1, 0,   1, 0, 4'b0000);
        add(0, 1, 0,   8, H, H,  1, 0,   3, 0, 4'b0000);
        add(0, 1, 0,  12, H, H,  1, 0,   6, 0, 4'b0000);
        add(0, 1, 0,  16, H, H,  1, 0,  10, 1, 4'b0000);
        add(0, 1, 0,  20, H, H,  1, 0,  14, 1, 4'b0000);
        add(0, 0, 0,   0, H, H,  0, 0,  14, 1, 4'b0000);
        add(1, 0, 0,   0, H, H,  0, 0,  14, 1, 4'b0000);
        // interleaved ch0/ch1
        add(0, 1, 0, 100, H, H,  1, 0,  25, 0, 4'b0000);
        add(0, 1, 1, 200, H, H,  1, 1,  50, 0, 4'b0000);
        add(0, 1, 0, 100, H, H,  1, 0,  50, 0, 4'b0000);
        add(0, 1, 1, 200, H, H,  1, 1, 100, 0, 4'b0000);
        add(0, 1, 0, 100, H, H,  1, 0,  75, 0, 4'b0000);
        add(0, 1, 1, 200, H, H,  1, 1, 150, 0, 4'b0000);
        add(0, 1, 0, 100, H, H,  1, 0, 100, 1, 4'b0000);
        add(0, 1, 1, 200, H, H,  1, 1, 200, 1, 4'b0000);
        add(1, 0, 0,   0, H, H,  0, 1, 200, 1, 4'b0000);
        // full-scale on ch3, alarm sets at avg == hi
        add(0, 1, 3,   H, H, H,  1, 3, 511, 0, 4'b0000);
        add(0, 1, 3,   H, H, H,  1, 3, 1023, 0, 4'b0000);
        add(0, 1, 3,   H, H, H,  1, 3, 1535, 0, 4'b0000);
        add(0, 1, 3,   H, H, H,  1, 3, 2047, 1, 4'b1000);
        add(1, 0, 0,   0, H, H,  0, 3, 2047, 1, 4'b0000);
        // hysteresis on ch2
        add(0, 1, 2, 100, 100, 90,  1, 2,  25, 0, 4'b0000);
        add(0, 1, 2, 100, 100, 90,  1, 2,  50, 0, 4'b0000);
        add(0, 1, 2, 100, 100, 90,  1, 2,  75, 0, 4'b0000);
        add(0, 1, 2, 100, 100, 90,  1, 2, 100, 1, 4'b0100);
        add(0, 1, 2,  92, 100, 90,  1, 2,  98, 1, 4'b0100);
        add(0, 1, 2,  92, 100, 90,  1, 2,  96, 1, 4'b0100);
        add(0, 1, 2,  92, 100, 90,  1, 2,  94, 1, 4'b0100);
        add(0, 1, 2,  92, 100, 90,  1, 2,  92, 1, 4'b0100);
        add(0, 1, 2,  80, 100, 90,  1, 2,  89, 1, 4'b0000);
        // ch0 full with alarm, then clear wins over a simultaneous sample
        add(0, 1, 0, 100, 100, 90,  1, 0,  25, 0, 4'b0000);
        add(0, 1, 0, 100, 100, 90,  1, 0,  50, 0, 4'b0000);
        add(0, 1, 0, 100, 100, 90,  1, 0,  75, 0, 4'b0000);
        add(0, 1, 0, 100, 100, 90,  1, 0, 100, 1, 4'b0001);
        add(1, 1, 0,  50, 100, 90,  0, 0, 100, 1, 4'b0000);
        add(0, 1, 0,  40, 100, 90,  1, 0,  10, 0, 4'b0000);

        #12;
        check("reset out_valid", 0, 32'(ov), 0);
        check("reset out_channel", 0, 32'(och), 0);
        check("reset result", 0, 32'(res), 0);
        check("reset window_full", 0, 32'(full), 0);
        check("reset alarm", 0, 32'(al), 0);
        check("reset err_channel", 0, 32'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        b_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clr = vecs[i].clr; vld = vecs[i].vld; ch = vecs[i].ch;
            data = vecs[i].data; hi = vecs[i].hi; lo = vecs[i].lo;
            @(posedge clk);
            #1;
            check("out_valid", i, 32'(ov), 32'(vecs[i].ov));
            check("out_channel", i, 32'(och), 32'(vecs[i].och));
            check("result_output", i, 32'(res), 32'(vecs[i].res));
            check("window_full", i, 32'(full), 32'(vecs[i].full));
            check("alarm", i, 32'(al), 32'(vecs[i].al));
            check("err_channel", i, 32'(err), 0);
        end
        @(negedge clk);
        clr = 1'b0; vld = 1'b0;

        // 3-channel build: valid sample, then out-of-range tag
        @(negedge clk);
        b_vld = 1'b1; b_ch = 2'd1; b_data = 11'd200;
        @(posedge clk); #1;
        check("b out_valid", 100, 32'(b_ov), 1);
        check("b out_channel", 100, 32'(b_och), 1);
        check("b result", 100, 32'(b_res), 50);
        check("b err_channel", 100, 32'(b_err), 0);
        @(negedge clk);
        b_ch = 2'd3; b_data = 11'd500;
        @(posedge clk); #1;
        check("b bad out_valid", 101, 32'(b_ov), 0);
        check("b bad err_channel", 101, 32'(b_err), 1);
        check("b bad result held", 101, 32'(b_res), 50);
        @(negedge clk);
        b_vld = 1'b0;
        @(posedge clk); #1;
        check("b err pulse ends", 102, 32'(b_err), 0);
        check("b idle out_valid", 102, 32'(b_ov), 0);
        // a pending out_valid must vanish as soon as reset asserts
        @(negedge clk);
        b_vld = 1'b1; b_ch = 2'd2; b_data = 11'd40;
        @(posedge clk); #1;
        check("b pre-reset out_valid", 103, 32'(b_ov), 1);
        check("b pre-reset result", 103, 32'(b_res), 10);
        check("b pre-reset out_channel", 103, 32'(b_och), 2);
        #2;
        b_rst = 1'b1;
        #1;
        check("b async out_valid", 104, 32'(b_ov), 0);
        check("b async out_channel", 104, 32'(b_och), 0);
        check("b async result", 104, 32'(b_res), 0);
        check("b async window_full", 104, 32'(b_full), 0);
        check("b async alarm", 104, 32'(b_al), 0);
        check("b async err_channel", 104, 32'(b_err), 0);
        @(negedge clk);
        b_vld = 1'b0;
        b_rst = 1'b0;
        @(posedge clk); #1;
        check("b post-reset out_valid", 105, 32'(b_ov), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
